mdu_pipe_unit: RTL and testbench

MDU_PIPE_UNIT -- requirements
Module: mdu_pipe_unit

---
 rtl/mdu_pipe_unit.sv | 136 +++++++++++++
 tb/tb_mdu_pipe_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_pipe_unit.sv
// Multiply/divide unit with HI/LO result registers.
// Operands are captured at issue; a down-counter models the operation
// latency and the result is committed to HI/LO on the final busy edge.
// Handshake: an operation is taken on a rising edge where start=1,
// busy=0 and flush=0; anything presented while busy is dropped, not queued.
module mdu_pipe_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] MLAT = 6'(MULT_LAT);
    localparam logic [5:0] DLAT = 6'(DIV_LAT);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [5:0]       count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_wr;
    logic               div_ovf;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;

    assign busy = (count != 6'd0);

    // Result datapath from the captured operands; consumed only on the final busy edge.
    always_comb begin
        prod    = '0;
        quo     = '0;
        rem     = '0;
        res_hi  = hi;
        res_lo  = lo;
        res_wr  = 1'b0;
        sa      = $signed(a_q);
        sb      = (b_q == '0) ? $signed({{(WIDTH-1){1'b0}}, 1'b1}) : $signed(b_q);
        div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == {WIDTH{1'b1}});
        case (op_q)
            OP_MULT[1:0]: begin
                // Sign-extend to 2*WIDTH; the low 2*WIDTH bits of the product are the signed result.
                prod   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
                res_wr = 1'b1;
            end
            OP_MULTU[1:0]: begin
                prod   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
                res_wr = 1'b1;
            end
            OP_DIV[1:0]: begin
                // Most-negative / -1 wraps to most-negative with zero remainder.
                if (div_ovf) begin
                    quo = a_q;
                    rem = '0;
                end else begin
                    quo = sa / sb;
                    rem = sa % sb;
                end
                res_hi = rem;
                res_lo = quo;
                res_wr = (b_q != '0);
            end
            default: begin
                quo    = a_q / ((b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q);
                rem    = a_q % ((b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q);
                res_hi = rem;
                res_lo = quo;
                res_wr = (b_q != '0);
            end
        endcase
    end

    // Issue, latency countdown, flush abort and HI/LO commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (busy) begin
            count <= count - 6'd1;
            if (count == 6'd1 && res_wr) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    op_q  <= op[1:0];
                    a_q   <= a;
                    b_q   <= b;
                    count <= MLAT;
                end
                OP_DIV, OP_DIVU: begin
                    op_q  <= op[1:0];
                    a_q   <= a;
                    b_q   <= b;
                    count <= DLAT;
                end
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_pipe_unit.sv
// Bench for mdu_pipe_unit: a default-parameter instance and a
// WIDTH=16 / MULT_LAT=1 / DIV_LAT=17 instance, checked against an
// arithmetic reference model of HI/LO.
module tb_mdu_pipe_unit;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        start0, flush0, busy0;
    logic [2:0]  op0;
    logic [31:0] a0, b0, hi0, lo0;
    logic        start1, flush1, busy1;
    logic [2:0]  op1;
    logic [15:0] a1, b1, hi1, lo1;

    mdu_pipe_unit dut0 (
        .clk(clk), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0),
        .flush(flush0), .busy(busy0), .hi(hi0), .lo(lo0)
    );

    mdu_pipe_unit #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(17)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
        .flush(flush1), .busy(busy1), .hi(hi1), .lo(lo1)
    );

    int errors = 0;
    int checks = 0;
    int wd[2]   = '{32, 16};
    int mlat[2] = '{5, 1};
    int dlat[2] = '{10, 17};
    logic [63:0] exp_hi[2];
    logic [63:0] exp_lo[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver
    task automatic drive(input int u, input logic st, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic fl);
        if (u == 0) begin
            start0 = st; op0 = op; a0 = a[31:0]; b0 = b[31:0]; flush0 = fl;
        end else begin
            start1 = st; op1 = op; a1 = a[15:0]; b1 = b[15:0]; flush1 = fl;
        end
    endtask

    function automatic logic [63:0] get_hi(input int u);
        return (u == 0) ? {32'd0, hi0} : {48'd0, hi1};
    endfunction
    function automatic logic [63:0] get_lo(input int u);
        return (u == 0) ? {32'd0, lo0} : {48'd0, lo1};
    endfunction
    function automatic logic [63:0] get_busy(input int u);
        return (u == 0) ? {63'd0, busy0} : {63'd0, busy1};
    endfunction

    // reference model: plain 64-bit arithmetic on the architectural result
    task automatic model(input int u, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m, ua, ub, pu;
        logic signed [63:0] sa, sb, p, q, r;
        int w;
        w  = wd[u];
        m  = (64'd1 << w) - 64'd1;
        ua = a & m;
        ub = b & m;
        sa = ua[w-1] ? $signed(ua - (64'd1 << w)) : $signed(ua);
        sb = ub[w-1] ? $signed(ub - (64'd1 << w)) : $signed(ub);
        case (op)
            3'd0: begin
                p = sa * sb;
                exp_hi[u] = (p >>> w) & m;
                exp_lo[u] = p & m;
            end
            3'd1: begin
                pu = ua * ub;
                exp_hi[u] = (pu >> w) & m;
                exp_lo[u] = pu & m;
            end
            3'd2: if (ub != 0) begin
                q = sa / sb;
                r = sa % sb;
                exp_hi[u] = r & m;
                exp_lo[u] = q & m;
            end
            3'd3: if (ub != 0) begin
                exp_hi[u] = ua % ub;
                exp_lo[u] = ua / ub;
            end
            3'd4: exp_hi[u] = ua;
            3'd5: exp_lo[u] = ua;
            default: ;
        endcase
    endtask

    // Issue one op from a negedge, check the busy window and final HI/LO.
    task automatic run(input int u, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int lat;
        logic [63:0] h0, l0;
        h0  = exp_hi[u];
        l0  = exp_lo[u];
        lat = (op <= 3'd1) ? mlat[u] : dlat[u];
        drive(u, 1'b1, op, a, b, 1'b0);
        @(negedge clk);
        drive(u, 1'b0, 3'd7, 64'd0, 64'd0, 1'b0);
        if (op <= 3'd3) begin
            for (int i = 0; i < lat; i++) begin
                chk("busy_window", get_busy(u), 64'd1);
                chk("hold_hi", get_hi(u), h0);
                chk("hold_lo", get_lo(u), l0);
                @(negedge clk);
            end
        end
        model(u, op, a, b);
        chk("busy_done", get_busy(u), 64'd0);
        chk("hi", get_hi(u), exp_hi[u]);
        chk("lo", get_lo(u), exp_lo[u]);
    endtask

    function automatic logic [63:0] rnd_operand(input int u);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'd1 << (wd[u] - 1);
            3: v = 64'd1;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    initial begin
        exp_hi = '{64'd0, 64'd0};
        exp_lo = '{64'd0, 64'd0};
        reset = 1'b0;
        drive(0, 1'b1, 3'd4, 64'hAAAA_AAAA, 64'd0, 1'b0);
        drive(1, 1'b1, 3'd0, 64'h1234, 64'h5678, 1'b0);
        repeat (3) @(negedge clk);
        // start held during reset must not be taken
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", get_busy(u), 64'd0);
            chk("rst_hi", get_hi(u), 64'd0);
            chk("rst_lo", get_lo(u), 64'd0);
        end
        drive(0, 1'b0, 3'd7, 64'd0, 64'd0, 1'b0);
        drive(1, 1'b0, 3'd7, 64'd0, 64'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // signed multiply of -1 * 2
        run(0, 3'd0, 64'hFFFF_FFFF, 64'd2);
        chk("mult_hi_const", get_hi(0), 64'hFFFF_FFFF);
        chk("mult_lo_const", get_lo(0), 64'hFFFF_FFFE);

        // divides
        run(0, 3'd3, 64'd7, 64'd2);
        chk("divu_lo_const", get_lo(0), 64'd3);
        chk("divu_hi_const", get_hi(0), 64'd1);
        run(0, 3'd2, 64'hFFFF_FFF9, 64'd2);
        chk("div_lo_const", get_lo(0), 64'hFFFF_FFFD);
        chk("div_hi_const", get_hi(0), 64'hFFFF_FFFF);
        run(0, 3'd2, 64'h8000_0000, 64'hFFFF_FFFF);
        chk("ovf_lo_const", get_lo(0), 64'h8000_0000);
        chk("ovf_hi_const", get_hi(0), 64'd0);

        // divide by zero leaves preset HI/LO alone
        run(0, 3'd4, 64'h1234_5678, 64'd0);
        run(0, 3'd5, 64'h1234_5678, 64'd0);
        run(0, 3'd3, 64'd99, 64'd0);
        chk("dz_hi_const", get_hi(0), 64'h1234_5678);
        chk("dz_lo_const", get_lo(0), 64'h1234_5678);
        run(0, 3'd2, 64'd99, 64'd0);

        // no-op opcodes
        run(0, 3'd6, 64'hDEAD, 64'd1);
        run(0, 3'd7, 64'hBEEF, 64'd1);

        // mtlo presented in busy cycle 2 is ignored
        drive(0, 1'b1, 3'd0, 64'd1000, 64'd3, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 3'd7, 64'd0, 64'd0, 1'b0);
        chk("ign_busy1", get_busy(0), 64'd1);
        @(negedge clk);
        chk("ign_busy2", get_busy(0), 64'd1);
        drive(0, 1'b1, 3'd5, 64'd5, 64'd0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 3'd7, 64'd0, 64'd0, 1'b0);
        chk("ign_lo_hold", get_lo(0), exp_lo[0]);
        for (int k = 3; k <= 5; k++) begin
            chk("ign_busy", get_busy(0), 64'd1);
            @(negedge clk);
        end
        model(0, 3'd0, 64'd1000, 64'd3);
        chk("ign_busy_done", get_busy(0), 64'd0);
        chk("ign_lo", get_lo(0), 64'd3000);
        chk("ign_hi", get_hi(0), 64'd0);

        // flush in the last busy cycle suppresses the write
        drive(0, 1'b1, 3'd1, 64'h7777, 64'h9999, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 3'd7, 64'd0, 64'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("fl_busy_last", get_busy(0), 64'd1);
        drive(0, 1'b0, 3'd7, 64'd0, 64'd0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 3'd7, 64'd0, 64'd0, 1'b0);
        chk("fl_busy", get_busy(0), 64'd0);
        chk("fl_hi", get_hi(0), exp_hi[0]);
        chk("fl_lo", get_lo(0), exp_lo[0]);

        // flush together with an idle start drops the issue
        drive(0, 1'b1, 3'd4, 64'h5555, 64'd0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 3'd7, 64'd0, 64'd0, 1'b0);
        chk("fl_issue_busy", get_busy(0), 64'd0);
        chk("fl_issue_hi", get_hi(0), exp_hi[0]);

        // asynchronous reset in busy cycle 3 of a divide
        run(1, 3'd4, 64'h00AB, 64'd0);
        drive(0, 1'b1, 3'd2, 64'd100, 64'd7, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 3'd7, 64'd0, 64'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", get_busy(0), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", get_busy(0), 64'd0);
        chk("arst_hi", get_hi(0), 64'd0);
        chk("arst_lo", get_lo(0), 64'd0);
        chk("arst_hi1", get_hi(1), 64'd0);
        exp_hi = '{64'd0, 64'd0};
        exp_lo = '{64'd0, 64'd0};
        @(negedge clk);
        reset = 1'b1;
        run(0, 3'd1, 64'd3, 64'd4);
        chk("post_rst_lo", get_lo(0), 64'd12);

        // narrow instance
        run(1, 3'd0, 64'h8000, 64'h8000);
        chk("w16_hi_const", get_hi(1), 64'h4000);
        chk("w16_lo_const", get_lo(1), 64'h0);
        run(1, 3'd2, 64'h8000, 64'hFFFF);
        run(1, 3'd2, 64'hFFF9, 64'd2);

        // randomized ops on both instances
        for (int n = 0; n < 40; n++) begin
            int u;
            logic [2:0] op;
            u  = n % 2;
            op = 3'($urandom_range(0, 6));
            run(u, op, rnd_operand(u), rnd_operand(u));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time limit
    initial begin
        #500000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
